// File: rtl/digit_scan_controller.sv
// Five-digit multiplexed display scanner.
// Walks digit positions 0..4, driving each for DIV cycles, followed by an
// optional BLANK_CYC blanking gap. bcd/dp_mask are snapshotted once per frame
// so that a frame never mixes old and new values. All outputs are registered.
//
// state | meaning
// IDLE  | display dark, waiting for en
// SHOW  | driving digit idx for DIV cycles
// GAP   | anti-ghosting blank between digits for BLANK_CYC cycles
module digit_scan_controller #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [19:0] bcd,
  input  logic [4:0]  dp_mask,
  input  logic        lz_en,
  output logic [2:0]  sel,
  output logic [3:0]  digit,
  output logic        dp,
  output logic        blank,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [19:0] DIV_LOAD = 20'(DIV - 1);
  localparam logic [19:0] GAP_LOAD = (BLANK_CYC > 0) ? 20'(BLANK_CYC - 1) : 20'd0;
  localparam bit          HAS_GAP  = (BLANK_CYC > 0);

  state_t      state, n_state;
  logic [2:0]  idx, n_idx;
  logic [19:0] cnt, n_cnt;
  logic [19:0] snap_bcd, n_snap_bcd;
  logic [4:0]  snap_dp, n_snap_dp;
  logic        n_fd;
  logic        advance;

  logic [4:0]  nz;
  logic        sup;
  logic [3:0]  nib;
  logic [2:0]  n_sel;
  logic [3:0]  n_digit;
  logic        n_dp;
  logic        n_blank;

  // Next-state, slot down-counter, digit index and snapshot reload.
  always_comb begin
    n_state    = state;
    n_idx      = idx;
    n_cnt      = cnt;
    n_snap_bcd = snap_bcd;
    n_snap_dp  = snap_dp;
    n_fd       = 1'b0;
    advance    = 1'b0;
    if (!en) begin
      n_state = IDLE;
      n_idx   = 3'd0;
      n_cnt   = 20'd0;
    end else begin
      case (state)
        IDLE: begin
          n_state    = SHOW;
          n_idx      = 3'd0;
          n_cnt      = DIV_LOAD;
          n_snap_bcd = bcd;
          n_snap_dp  = dp_mask;
        end
        SHOW: begin
          if (cnt != 20'd0) begin
            n_cnt = cnt - 20'd1;
          end else if (HAS_GAP) begin
            n_state = GAP;
            n_cnt   = GAP_LOAD;
          end else begin
            advance = 1'b1;
          end
        end
        GAP: begin
          if (cnt != 20'd0) n_cnt = cnt - 20'd1;
          else              advance = 1'b1;
        end
        default: n_state = IDLE;
      endcase
      if (advance) begin
        n_state = SHOW;
        n_cnt   = DIV_LOAD;
        if (idx == 3'd4) begin
          n_idx      = 3'd0;
          n_snap_bcd = bcd;
          n_snap_dp  = dp_mask;
          n_fd       = 1'b1;
        end else begin
          n_idx = idx + 3'd1;
        end
      end
    end
  end

  // Output values derived from the upcoming state so the registers present them in step with it.
  always_comb begin
    for (int k = 0; k < 5; k++) nz[k] = |n_snap_bcd[4*k +: 4];
    sup = lz_en && (n_idx != 3'd0) && ((nz >> n_idx) == 5'd0);
    case (n_idx)
      3'd1:    nib = n_snap_bcd[7:4];
      3'd2:    nib = n_snap_bcd[11:8];
      3'd3:    nib = n_snap_bcd[15:12];
      3'd4:    nib = n_snap_bcd[19:16];
      default: nib = n_snap_bcd[3:0];
    endcase
    n_sel   = 3'd7;
    n_digit = 4'd0;
    n_dp    = 1'b0;
    n_blank = 1'b1;
    case (n_state)
      SHOW: begin
        n_sel   = n_idx;
        n_digit = nib;
        n_dp    = n_snap_dp[n_idx] & ~sup;
        n_blank = sup;
      end
      GAP: n_digit = digit;
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= 3'd0;
      cnt        <= 20'd0;
      snap_bcd   <= 20'd0;
      snap_dp    <= 5'd0;
      sel        <= 3'd7;
      digit      <= 4'd0;
      dp         <= 1'b0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= n_state;
      idx        <= n_idx;
      cnt        <= n_cnt;
      snap_bcd   <= n_snap_bcd;
      snap_dp    <= n_snap_dp;
      sel        <= n_sel;
      digit      <= n_digit;
      dp         <= n_dp;
      blank      <= n_blank;
      frame_done <= n_fd;
    end
  end

endmodule

// File: tb/tb_digit_scan_controller.sv
// Directed bench for digit_scan_controller: one instance at DIV=4/BLANK_CYC=2,
// a second at DIV=1/BLANK_CYC=0 for the gapless corner.
module tb_digit_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        en_b = 1'b0;
  logic [19:0] bcd = 20'd0;
  logic [4:0]  dp_mask = 5'd0;
  logic        lz_en = 1'b0;

  logic [2:0] sel_a, sel_b;
  logic [3:0] digit_a, digit_b;
  logic       dp_a, dp_b, blank_a, blank_b, fd_a, fd_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  digit_scan_controller #(.DIV(4), .BLANK_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .en(en), .bcd(bcd), .dp_mask(dp_mask), .lz_en(lz_en),
    .sel(sel_a), .digit(digit_a), .dp(dp_a), .blank(blank_a), .frame_done(fd_a)
  );

  digit_scan_controller #(.DIV(1), .BLANK_CYC(0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .bcd(bcd), .dp_mask(dp_mask), .lz_en(lz_en),
    .sel(sel_b), .digit(digit_b), .dp(dp_b), .blank(blank_b), .frame_done(fd_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return dut_a to IDLE with en low.
  task automatic park();
    en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    tick();
    tests++;
    if ({sel_a, digit_a, dp_a, blank_a, fd_a} !== {3'd7, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got sel=%0d digit=%0d dp=%b blank=%b fd=%b, want sel=7 digit=0 dp=0 blank=1 fd=0",
               sel_a, digit_a, dp_a, blank_a, fd_a);
    end
    en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Basic scan: 6-cycle slots (4 SHOW + 2 GAP), 30-cycle frames.
  task automatic test_scan();
    logic [2:0] exp_sel;
    logic [3:0] exp_dig;
    logic       exp_blank, exp_fd;
    int slot, pos;
    bcd = 20'h43210; dp_mask = 5'd0; lz_en = 1'b0; en = 1'b1;
    for (int t = 0; t < 62; t++) begin
      tick();
      slot = (t % 30) / 6;
      pos  = t % 6;
      exp_sel   = (pos < 4) ? 3'(slot) : 3'd7;
      exp_dig   = 4'(slot);
      exp_blank = (pos >= 4);
      exp_fd    = (t > 0) && (t % 30 == 0);
      tests++;
      if (sel_a !== exp_sel || digit_a !== exp_dig || blank_a !== exp_blank || dp_a !== 1'b0) begin
        fails++;
        $display("FAIL scan_t%0d: got sel=%0d digit=%0d blank=%b dp=%b, want sel=%0d digit=%0d blank=%b dp=0",
                 t, sel_a, digit_a, blank_a, dp_a, exp_sel, exp_dig, exp_blank);
      end
      tests++;
      if (fd_a !== exp_fd) begin
        fails++;
        $display("FAIL scan_fd_t%0d: got %b, want %b", t, fd_a, exp_fd);
      end
    end
    park();
  endtask

  // Leading-zero suppression: two patterns, one frame each from a fresh start.
  task automatic test_lz();
    logic [19:0] pat   [2] = '{20'h00050, 20'h00000};
    logic [4:0]  blk   [2] = '{5'b11100, 5'b11110};
    logic [3:0]  exp_dig;
    logic        exp_blank;
    lz_en = 1'b1; dp_mask = 5'b11111;
    for (int p = 0; p < 2; p++) begin
      bcd = pat[p];
      en  = 1'b1;
      for (int k = 0; k < 5; k++) begin
        tick();
        exp_dig   = (p == 0 && k == 1) ? 4'd5 : 4'd0;
        exp_blank = blk[p][k];
        tests++;
        if (sel_a !== 3'(k) || digit_a !== exp_dig || blank_a !== exp_blank || dp_a !== ~exp_blank) begin
          fails++;
          $display("FAIL lz_p%0d_k%0d: got sel=%0d digit=%0d blank=%b dp=%b, want sel=%0d digit=%0d blank=%b dp=%b",
                   p, k, sel_a, digit_a, blank_a, dp_a, k, exp_dig, exp_blank, ~exp_blank);
        end
        for (int g = 0; g < 5; g++) tick();
      end
      park();
    end
    lz_en = 1'b0; dp_mask = 5'd0;
  endtask

  // bcd changed mid-frame must not tear the current frame.
  task automatic test_tearing();
    logic [3:0] exp_dig;
    bcd = 20'h11111; en = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (t % 6 < 4) begin
        exp_dig = (t < 30) ? 4'd1 : 4'd2;
        tests++;
        if (digit_a !== exp_dig) begin
          fails++;
          $display("FAIL tearing_t%0d: got digit=%0d, want %0d", t, digit_a, exp_dig);
        end
      end
      if (t == 12) bcd = 20'h22222;
    end
    park();
  endtask

  // en dropped during digit 3, then re-enabled.
  task automatic test_abort();
    bcd = 20'h43210; en = 1'b1;
    for (int t = 0; t < 19; t++) tick();
    tests++;
    if (sel_a !== 3'd3) begin
      fails++;
      $display("FAIL abort_pre: got sel=%0d, want 3", sel_a);
    end
    en = 1'b0;
    tick();
    tests++;
    if (sel_a !== 3'd7 || blank_a !== 1'b1 || fd_a !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got sel=%0d blank=%b fd=%b, want sel=7 blank=1 fd=0", sel_a, blank_a, fd_a);
    end
    bcd = 20'h98765; en = 1'b1;
    tick();
    tests++;
    if (sel_a !== 3'd0 || digit_a !== 4'd5 || blank_a !== 1'b0 || fd_a !== 1'b0) begin
      fails++;
      $display("FAIL abort_restart: got sel=%0d digit=%0d blank=%b fd=%b, want sel=0 digit=5 blank=0 fd=0",
               sel_a, digit_a, blank_a, fd_a);
    end
    park();
  endtask

  // Gapless single-cycle slots; non-BCD nibbles pass through and count as nonzero.
  task automatic test_div1();
    logic [19:0] v;
    logic [3:0]  exp_dig;
    bcd = 20'hFA000; lz_en = 1'b1; dp_mask = 5'd0; en_b = 1'b1;
    v = bcd;
    for (int t = 0; t < 12; t++) begin
      tick();
      exp_dig = v[4*(t%5) +: 4];
      tests++;
      if (sel_b !== 3'(t % 5) || digit_b !== exp_dig || blank_b !== 1'b0) begin
        fails++;
        $display("FAIL div1_t%0d: got sel=%0d digit=%0d blank=%b, want sel=%0d digit=%0d blank=0",
                 t, sel_b, digit_b, blank_b, t % 5, exp_dig);
      end
      tests++;
      if (fd_b !== ((t > 0) && (t % 5 == 0))) begin
        fails++;
        $display("FAIL div1_fd_t%0d: got %b, want %b", t, fd_b, (t > 0) && (t % 5 == 0));
      end
    end
    en_b = 1'b0; lz_en = 1'b0;
    tick();
  endtask

  // Reset pulsed during a GAP with en held high.
  task automatic test_rst_gap();
    bcd = 20'h43210; en = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    tests++;
    if (sel_a !== 3'd7 || blank_a !== 1'b1 || digit_a !== 4'd0) begin
      fails++;
      $display("FAIL rst_gap_pre: got sel=%0d blank=%b digit=%0d, want sel=7 blank=1 digit=0", sel_a, blank_a, digit_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({sel_a, digit_a, dp_a, blank_a, fd_a} !== {3'd7, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL rst_gap_idle: got sel=%0d digit=%0d dp=%b blank=%b fd=%b, want 7/0/0/1/0",
               sel_a, digit_a, dp_a, blank_a, fd_a);
    end
    tick();
    tests++;
    if (sel_a !== 3'd0 || blank_a !== 1'b0 || digit_a !== 4'd0) begin
      fails++;
      $display("FAIL rst_gap_restart: got sel=%0d blank=%b digit=%0d, want sel=0 blank=0 digit=0", sel_a, blank_a, digit_a);
    end
    for (int t = 0; t < 4; t++) tick();
    tests++;
    if (sel_a !== 3'd7) begin
      fails++;
      $display("FAIL rst_gap_after: got sel=%0d, want 7", sel_a);
    end
    park();
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_tearing();
    test_abort();
    test_div1();
    test_rst_gap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/digit_scan_controller.md
DIGIT_SCAN_CONTROLLER -- requirements
Module: digit_scan_controller

Interface
REQ-001 Parameter DIV, default 50000: clock cycles each digit is driven per scan slot; legal range 1..2^20-1.
REQ-002 Parameter BLANK_CYC, default 16: inter-digit blanking cycles (anti-ghosting); legal range 0..255.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  scan enable; 0 = display dark.
REQ-006 bcd  input  20  five BCD digits; digit k on bcd[4k+3:4k]; digit 0 least significant.
REQ-007 dp_mask  input  5  decimal-point request per digit; bit k maps to digit k.
REQ-008 lz_en  input  1  1 = suppress leading zeros.
REQ-009 sel  output  3  digit position to the 3-to-5 position decoder; 0..4 = digit, 7 = none lit.
REQ-010 digit  output  4  BCD value for the selected digit.
REQ-011 dp  output  1  decimal point for the selected digit.
REQ-012 blank  output  1  1 = segments off.
REQ-013 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 All outputs shall be registered; no combinational path shall exist from any input to any output.
REQ-015 The FSM shall have exactly three states: IDLE, SHOW and GAP; it holds a digit index idx (0..4), a slot counter and a 20-bit/5-bit snapshot of bcd/dp_mask.
REQ-016 IDLE: sel=7, blank=1, digit=0, dp=0, idx=0; if en=1, the next state shall be SHOW with idx=0, and the snapshot shall load bcd and dp_mask on that same edge.
REQ-017 SHOW: sel=idx, digit=snapshot digit idx, dp=snapshot dp bit idx, blank=suppress(idx); the FSM shall stay in SHOW for exactly DIV cycles.
REQ-018 After SHOW, the FSM shall enter GAP for exactly BLANK_CYC cycles with sel=7, blank=1, dp=0, digit held; if BLANK_CYC=0, GAP shall be skipped.
REQ-019 On leaving GAP (or SHOW if BLANK_CYC=0), idx shall increment; 4 shall wrap to 0.
REQ-020 On the 4->0 wrap, the snapshot shall reload from bcd and dp_mask.
REQ-021 On the 4->0 wrap, frame_done shall be 1 for exactly the first SHOW cycle of the new frame.
REQ-022 Frame period shall be 5*(DIV+BLANK_CYC) cycles.
REQ-023 suppress(k) shall be 1 if lz_en=1, k>=1, and snapshot digits k..4 are all zero; digit 0 shall never be suppressed.
REQ-024 A suppressed digit shall still drive sel=k, with blank=1 and dp=0.
REQ-025 bcd changes mid-frame shall not affect displayed values until the next wrap (no tearing).
REQ-026 Non-BCD nibbles (10..15) shall pass through to digit unchanged and shall count as nonzero for suppression.
REQ-027 en=0 in any state shall force IDLE on the next edge: counters and idx shall clear, and no frame_done shall be generated; a partial frame shall not resume.
REQ-028 en re-asserted shall restart at idx 0 with a fresh snapshot, per REQ-016.
REQ-029 sel shall never take the values 5 or 6.

Reset
REQ-030 rst=1 at a clock edge shall override en and set state=IDLE, idx=0, counters=0, snapshot=0, sel=7, digit=0, dp=0, blank=1, frame_done=0.
REQ-031 rst asserted mid-SHOW or mid-GAP shall take effect on that edge, and outputs shall match REQ-030 on the following cycle.

Verification (DIV=4, BLANK_CYC=2 unless noted)
REQ-032 Reset, then en=1, bcd=0x43210, dp_mask=0, lz_en=0 -> sel sequence 0x4,7x2,1x4,7x2,...,4x4,7x2, digit 0..4 in slots; frame_done pulses every 30 cycles, aligned with the sel=0 first cycle.
REQ-033 lz_en=1, bcd=0x00050 -> digits 4,3,2 have blank=1, digits 1,0 have blank=0; with bcd=0x00000, only digit 0 is lit, showing 0.
REQ-034 bcd changed from 0x11111 to 0x22222 while sel=2 -> digits 2..4 still show 1; the next frame shows 2.
REQ-035 en dropped while sel=3 -> next cycle sel=7, blank=1; after en=1, sel=0 follows one cycle later with a new snapshot; no frame_done is emitted at the abort.
REQ-036 BLANK_CYC=0, DIV=1 -> sel steps 0,1,2,3,4,0 on consecutive cycles; frame_done is high every 5th cycle.
REQ-037 rst pulsed mid-GAP with en=1 held -> one cycle of IDLE outputs, then the scan restarts at sel=0.
